// File: rtl/spram_boot_pkg.sv
// Shared types and constants for the multi-image SPRAM boot loader.
// The state set includes CSUM, which is only reached when BOOT_CHECKSUM_EN is defined.
package spram_boot_pkg;

    localparam int DATA_W          = 32;
    localparam int END_MODE_MARKER = 0;
    localparam int END_MODE_LENGTH = 1;

    typedef enum logic [2:0] {
        START,
        HDR,
        LOAD,
        CSUM,
        GAP,
        DONE
    } boot_state_e;

    // Flash byte address of image idx; wraps at 24 bits.
    function automatic logic [23:0] image_addr(input logic [23:0] base,
                                               input logic [23:0] stride,
                                               input logic [1:0]  idx);
        return base + stride * {22'd0, idx};
    endfunction

endpackage

// File: rtl/spram_bank_port_mux.sv
// Per-bank port select between the boot loader and the SoC memory port,
// plus the SoC read-valid register (read strobe delayed by one cycle).
module spram_bank_port_mux
    import spram_boot_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ldr_sel,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_din,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] soc_addr,
    input  logic [DATA_W-1:0] soc_din,
    input  logic              soc_we,
    input  logic [3:0]        soc_maskwe,
    input  logic              soc_re,
    output logic              soc_rvalid,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_din,
    output logic              bank_we,
    output logic [3:0]        bank_maskwe
);

    // While the loader owns the bank, SoC writes are dropped.
    always_comb begin
        bank_addr   = soc_addr;
        bank_din    = soc_din;
        bank_we     = soc_we;
        bank_maskwe = soc_maskwe;
        if (ldr_sel) begin
            bank_addr   = ldr_addr;
            bank_din    = ldr_din;
            bank_we     = ldr_we;
            bank_maskwe = 4'hF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            soc_rvalid <= 1'b0;
        end else begin
            soc_rvalid <= soc_re;
        end
    end

endmodule

// File: rtl/spram_multi_boot_loader.sv
// Sequentially copies NUM_BANKS flash images into SPRAM banks and releases SoC reset afterwards.
// Optional feature macro: BOOT_CHECKSUM_EN (trailing 32-bit wrapping-sum word after each payload).
module spram_multi_boot_loader
    import spram_boot_pkg::*;
#(
    parameter int          NUM_BANKS    = 2,
    parameter int          ADDR_W       = 14,
    parameter logic [23:0] FLASH_BASE   = 24'h030000,
    parameter logic [23:0] FLASH_STRIDE = 24'h020000,
    parameter int          END_MODE     = 0,
    parameter logic [31:0] END_MARKER   = 32'hFFFF_FFFF,
    parameter int          GAP_CYCLES   = 13
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        ip_done_i,
    output logic [23:0]                 fetch_addr_o,
    output logic                        fetch_req_o,
    output logic                        fetch_rst_o,
    input  logic                        fetch_vld_i,
    input  logic [31:0]                 fetch_data_i,
    input  logic [NUM_BANKS*ADDR_W-1:0] soc_addr_i,
    input  logic [NUM_BANKS*32-1:0]     soc_din_i,
    input  logic [NUM_BANKS-1:0]        soc_we_i,
    input  logic [NUM_BANKS*4-1:0]      soc_maskwe_i,
    input  logic [NUM_BANKS-1:0]        soc_re_i,
    output logic [NUM_BANKS-1:0]        soc_rvalid_o,
    output logic [NUM_BANKS*ADDR_W-1:0] bank_addr_o,
    output logic [NUM_BANKS*32-1:0]     bank_din_o,
    output logic [NUM_BANKS-1:0]        bank_we_o,
    output logic [NUM_BANKS*4-1:0]      bank_maskwe_o,
    output logic                        load_done_o,
    output logic                        soc_rstn_o,
    output logic [NUM_BANKS-1:0]        err_o
);

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_e END_ST = CSUM;
`else
    localparam boot_state_e END_ST = GAP;
`endif
    localparam boot_state_e FIRST_ST = (END_MODE == END_MODE_LENGTH) ? HDR : LOAD;

    boot_state_e          state_q, state_n;
    logic [1:0]           bank_q;
    logic [ADDR_W:0]      wcnt_q;
    logic [31:0]          rem_q;
    logic [15:0]          gap_q;
    logic [23:0]          addr_q;
    logic                 load_done_q;
    logic                 rstn_q;
    logic [NUM_BANKS-1:0] err_q;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]          sum_q;
`endif

    logic                 last_bank;
    logic                 full;
    logic                 is_marker;
    logic                 last_word;
    logic                 ldr_we;
    logic                 overflow;
    logic                 csum_bad;
    logic [NUM_BANKS-1:0] ldr_sel;

    // wcnt_q carries one extra bit so "address all-ones and already written" is just the MSB.
    assign last_bank = (bank_q == 2'(NUM_BANKS - 1));
    assign full      = wcnt_q[ADDR_W];
    assign is_marker = (END_MODE == END_MODE_MARKER) && (fetch_data_i == END_MARKER);
    assign last_word = (END_MODE == END_MODE_LENGTH) && (rem_q == 32'd1);
    assign ldr_we    = (state_q == LOAD) && fetch_vld_i && !is_marker && !full;
    assign overflow  = (state_q == LOAD) && fetch_vld_i && !is_marker && full;
`ifdef BOOT_CHECKSUM_EN
    assign csum_bad  = (state_q == CSUM) && fetch_vld_i && (fetch_data_i != sum_q);
`else
    assign csum_bad  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= START;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            START: state_n = FIRST_ST;
            HDR: begin
                if (fetch_vld_i) begin
                    state_n = (fetch_data_i == 32'd0) ? END_ST : LOAD;
                end
            end
            LOAD: begin
                if (fetch_vld_i) begin
                    if (is_marker) begin
                        state_n = END_ST;
                    end else if (full) begin
                        state_n = GAP;
                    end else if (last_word) begin
                        state_n = END_ST;
                    end
                end
            end
            CSUM: begin
                if (fetch_vld_i) begin
                    state_n = GAP;
                end
            end
            GAP: begin
                if (gap_q == 16'(GAP_CYCLES - 1)) begin
                    state_n = last_bank ? DONE : FIRST_ST;
                end
            end
            DONE:    state_n = DONE;
            default: state_n = START;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bank_q      <= 2'd0;
            wcnt_q      <= '0;
            rem_q       <= 32'd0;
            gap_q       <= 16'd0;
            addr_q      <= 24'd0;
            load_done_q <= 1'b0;
            rstn_q      <= 1'b0;
            err_q       <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q       <= 32'd0;
`endif
        end else begin
            gap_q  <= (state_q == GAP && state_n == GAP) ? gap_q + 16'd1 : 16'd0;
            rstn_q <= load_done_q & ip_done_i;
            if (state_q == HDR && fetch_vld_i) begin
                rem_q <= fetch_data_i;
            end
            if (ldr_we) begin
                wcnt_q <= wcnt_q + (ADDR_W + 1)'(1);
                rem_q  <= rem_q - 32'd1;
`ifdef BOOT_CHECKSUM_EN
                sum_q  <= sum_q + fetch_data_i;
`endif
            end
            if (state_q == GAP) begin
                wcnt_q <= '0;
`ifdef BOOT_CHECKSUM_EN
                sum_q  <= 32'd0;
`endif
            end
            if (state_q == START) begin
                addr_q <= image_addr(FLASH_BASE, FLASH_STRIDE, 2'd0);
            end
            if (state_q == GAP && state_n == FIRST_ST) begin
                bank_q <= bank_q + 2'd1;
                addr_q <= image_addr(FLASH_BASE, FLASH_STRIDE, bank_q + 2'd1);
            end
            for (int i = 0; i < NUM_BANKS; i++) begin
                if ((overflow || csum_bad) && bank_q == 2'(i)) begin
                    err_q[i] <= 1'b1;
                end
            end
            if (state_n == DONE) begin
                load_done_q <= 1'b1;
            end
        end
    end

    assign fetch_addr_o = addr_q;
    assign fetch_req_o  = (state_q == HDR) || (state_q == LOAD);
    assign fetch_rst_o  = (state_q == START) || (state_q == GAP);
    assign load_done_o  = load_done_q;
    assign soc_rstn_o   = rstn_q;
    assign err_o        = err_q;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        assign ldr_sel[i] = fetch_req_o && (bank_q == 2'(i));

        spram_bank_port_mux #(
            .ADDR_W(ADDR_W)
        ) u_mux (
            .clk        (clk_i),
            .rst        (rst_i),
            .ldr_sel    (ldr_sel[i]),
            .ldr_addr   (wcnt_q[ADDR_W-1:0]),
            .ldr_din    (fetch_data_i),
            .ldr_we     (ldr_we),
            .soc_addr   (soc_addr_i[i*ADDR_W +: ADDR_W]),
            .soc_din    (soc_din_i[i*32 +: 32]),
            .soc_we     (soc_we_i[i]),
            .soc_maskwe (soc_maskwe_i[i*4 +: 4]),
            .soc_re     (soc_re_i[i]),
            .soc_rvalid (soc_rvalid_o[i]),
            .bank_addr  (bank_addr_o[i*ADDR_W +: ADDR_W]),
            .bank_din   (bank_din_o[i*32 +: 32]),
            .bank_we    (bank_we_o[i]),
            .bank_maskwe(bank_maskwe_o[i*4 +: 4])
        );
    end

endmodule

// File: tb/tb_spram_multi_boot_loader.sv
// Bench: two loaders (marker framing and length framing, 16-word banks) fed with random images;
// bank writes are captured into a behavioural SPRAM and compared with the expected image contents.
module tb_spram_multi_boot_loader;

    localparam logic [31:0] M = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, ip_done, clr;
    logic [1:0]  fvld;
    logic [31:0] fdat [2];
    logic [7:0]  soc_addr, soc_mask;
    logic [63:0] soc_din;
    logic [1:0]  soc_we, soc_re;
    logic [23:0] faddr [2];
    logic [1:0]  freq, frst, done, rstn;
    logic [1:0]  rvld [2];
    logic [1:0]  bwe [2];
    logic [1:0]  err [2];
    logic [7:0]  baddr [2];
    logic [7:0]  bmask [2];
    logic [63:0] bdin [2];

    logic [31:0] cap_mem [2][2][16];
    logic [31:0] exp_mem [2][2][16];
    logic [1:0]  eerr [2];
    logic [31:0] pay [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    spram_multi_boot_loader #(.NUM_BANKS(2), .ADDR_W(4), .END_MODE(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .ip_done_i(ip_done),
        .fetch_addr_o(faddr[0]), .fetch_req_o(freq[0]), .fetch_rst_o(frst[0]),
        .fetch_vld_i(fvld[0]), .fetch_data_i(fdat[0]),
        .soc_addr_i(soc_addr), .soc_din_i(soc_din), .soc_we_i(soc_we),
        .soc_maskwe_i(soc_mask), .soc_re_i(soc_re), .soc_rvalid_o(rvld[0]),
        .bank_addr_o(baddr[0]), .bank_din_o(bdin[0]), .bank_we_o(bwe[0]),
        .bank_maskwe_o(bmask[0]), .load_done_o(done[0]), .soc_rstn_o(rstn[0]),
        .err_o(err[0])
    );

    spram_multi_boot_loader #(.NUM_BANKS(2), .ADDR_W(4), .END_MODE(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .ip_done_i(ip_done),
        .fetch_addr_o(faddr[1]), .fetch_req_o(freq[1]), .fetch_rst_o(frst[1]),
        .fetch_vld_i(fvld[1]), .fetch_data_i(fdat[1]),
        .soc_addr_i(soc_addr), .soc_din_i(soc_din), .soc_we_i(soc_we),
        .soc_maskwe_i(soc_mask), .soc_re_i(soc_re), .soc_rvalid_o(rvld[1]),
        .bank_addr_o(baddr[1]), .bank_din_o(bdin[1]), .bank_we_o(bwe[1]),
        .bank_maskwe_o(bmask[1]), .load_done_o(done[1]), .soc_rstn_o(rstn[1]),
        .err_o(err[1])
    );

    // Behavioural SPRAM with byte write masks; contents survive DUT reset.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < 16; a++) begin
                    if (clr) begin
                        cap_mem[d][b][a] <= 32'd0;
                    end else if (bwe[d][b] && baddr[d][b*4 +: 4] == 4'(a)) begin
                        for (int k = 0; k < 4; k++) begin
                            if (bmask[d][b*4+k]) cap_mem[d][b][a][k*8 +: 8] <= bdin[d][b*32+k*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send(input int d, input logic [31:0] w);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        fvld[d] = 1'b1;
        fdat[d] = w;
        @(negedge clk);
        fvld[d] = 1'b0;
    endtask

    task automatic wait_req(input int d);
        int k = 0;
        while (!freq[d] && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("fetch_req_wait", 32'(freq[d]), 32'd1);
    endtask

    task automatic wait_done(input int d);
        int k = 0;
        while (!done[d] && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("load_done_wait", 32'(done[d]), 32'd1);
    endtask

    task automatic soc_check(input int d, input int lb);
        logic [1:0] r;
        soc_addr = 8'($urandom);
        soc_din  = {$urandom, $urandom};
        soc_mask = 8'($urandom);
        soc_we   = 2'b11;
        r        = 2'($urandom_range(0, 3));
        soc_re   = r;
        #1;
        for (int b = 0; b < 2; b++) begin
            if (b == lb) begin
                chk("ldr_bank_we", 32'(bwe[d][b]), 32'd0);
                chk("ldr_bank_mask", 32'(bmask[d][b*4 +: 4]), 32'hF);
            end else begin
                chk("soc_addr", 32'(baddr[d][b*4 +: 4]), 32'(soc_addr[b*4 +: 4]));
                chk("soc_din", bdin[d][b*32 +: 32], soc_din[b*32 +: 32]);
                chk("soc_we", 32'(bwe[d][b]), 32'd1);
                chk("soc_mask", 32'(bmask[d][b*4 +: 4]), 32'(soc_mask[b*4 +: 4]));
            end
        end
        soc_we = 2'b00;
        @(negedge clk);
        chk("rvalid", 32'(rvld[d]), 32'(r));
        soc_re = 2'b00;
    endtask

    // Frames pay[] as one image for loader d / bank b and records what the bank must hold.
    task automatic run_image(input int d, input int b);
        logic [31:0] sum;
        logic [23:0] ea;
        int          n;
        sum = 32'd0;
        n   = pay.size();
        ea  = 24'h030000 + 24'(b) * 24'h020000;
        wait_req(d);
        chk("fetch_addr", 32'(faddr[d]), 32'(ea));
        if (d == 0) soc_check(0, b);
        if (d == 1) send(d, 32'(n));
        for (int i = 0; i < n && i <= 16; i++) begin
            send(d, pay[i]);
            if (i < 16) begin
                exp_mem[d][b][i] = pay[i];
                sum += pay[i];
            end
        end
        if (n > 16) begin
            eerr[d][b] = 1'b1;
        end else begin
            if (d == 0) send(d, M);
`ifdef BOOT_CHECKSUM_EN
            send(d, sum);
`endif
        end
        send(d, $urandom);
    endtask

    task automatic rnd_pay(input int n, input bit allow_m);
        logic [31:0] w;
        pay.delete();
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (!allow_m && w == M) w = 32'd0;
            pay.push_back(w);
        end
    endtask

    task automatic check_mems();
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < 16; a++) begin
                    chk($sformatf("mem%0d_b%0d_a%0d", d, b, a), cap_mem[d][b][a], exp_mem[d][b][a]);
                end
            end
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        eerr[0] = 2'b00;
        eerr[1] = 2'b00;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b1; ip_done = 1'b0;
        fvld = 2'b00; fdat[0] = 32'd0; fdat[1] = 32'd0;
        soc_addr = 8'd0; soc_din = 64'd0; soc_we = 2'b00; soc_mask = 8'd0; soc_re = 2'b00;
        eerr[0] = 2'b00; eerr[1] = 2'b00;
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 16; a++) exp_mem[d][b][a] = 32'd0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_fetch_rst", 32'(frst[d]), 32'd1);
            chk("rst_fetch_req", 32'(freq[d]), 32'd0);
            chk("rst_load_done", 32'(done[d]), 32'd0);
            chk("rst_soc_rstn", 32'(rstn[d]), 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
            chk("rst_rvalid", 32'(rvld[d]), 32'd0);
            chk("rst_fetch_addr", 32'(faddr[d]), 32'd0);
        end
        rst = 1'b0;

        // Directed images, then a random second image on the length-framed loader.
        pay = '{32'd1, 32'd2, 32'd3};
        run_image(0, 0);
        pay = '{32'hA, 32'hB};
        run_image(0, 1);
        pay = '{M, 32'd5, 32'd6};
        run_image(1, 0);
        rnd_pay($urandom_range(0, 4), 1'b1);
        run_image(1, 1);
        wait_done(0);
        wait_done(1);
        send(0, 32'h1234_5678);
        soc_check(0, -1);
        for (int d = 0; d < 2; d++) chk("err_clean", 32'(err[d]), 32'(eerr[d]));
        check_mems();

        repeat (100) @(negedge clk);
        chk("rstn_wait_ip", 32'(rstn), 32'd0);
        ip_done = 1'b1;
        chk("rstn_same_cycle", 32'(rstn), 32'd0);
        @(negedge clk);
        chk("rstn_rise", 32'(rstn), 32'h3);
        chk("done_sticky", 32'(done), 32'h3);

        // Reset in the middle of bank 1, then overflow bank 0.
        ip_done = 1'b0;
        pulse_rst();
        rnd_pay(2, 1'b0);
        run_image(0, 0);
        wait_req(0);
        chk("bank1_addr", 32'(faddr[0]), 32'h050000);
        pay = '{32'hC0FFEE00};
        send(0, pay[0]);
        exp_mem[0][1][0] = pay[0];
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_fetch_rst", 32'(frst[0]), 32'd1);
        chk("midrst_load_done", 32'(done[0]), 32'd0);
        chk("midrst_req", 32'(freq[0]), 32'd0);
        rst = 1'b0;
        eerr[0] = 2'b00;
        eerr[1] = 2'b00;
        rnd_pay(17, 1'b0);
        run_image(0, 0);
        rnd_pay($urandom_range(1, 5), 1'b0);
        run_image(0, 1);
        rnd_pay($urandom_range(1, 6), 1'b1);
        run_image(1, 0);
        rnd_pay($urandom_range(0, 5), 1'b1);
        run_image(1, 1);
        wait_done(0);
        wait_done(1);
        chk("err_overflow", 32'(err[0]), 32'(eerr[0]));
        chk("err_dut1", 32'(err[1]), 32'(eerr[1]));
        check_mems();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
